adder_tree_acc: RTL and testbench

Pipelined signed N-input adder tree with valid/last sideband and a group accumulator behind the tree. It sums each input beat across N lanes, then accumulates consecutive beat sums up to and including the beat flagged last. It emits one result per group, with a beat count and an overflow flag. It sits after the multiplier array in the dot-product datapath and replaces the unpipelined-sideband tree there.

---
 rtl/adder_tree_pkg.sv | 35 +++
 rtl/tree_level.sv | 39 +++
 rtl/adder_tree_acc.sv | 137 +++++++++++++
 tb/tb_adder_tree_acc.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Sizing helpers and the accumulator state type shared by the adder tree
// accumulator and its pipeline levels.
package adder_tree_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } acc_state_t;

    // A single lane still gets one pass-through register level.
    function automatic int tree_depth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Power-of-two lane counts carry one guard bit above the log2 growth.
    function automatic int tree_width(input int n, input int w);
        int grow;
        grow = $clog2(n);
        if ((n & (n - 1)) == 0) begin
            grow = grow + 1;
        end
        return w + grow;
    endfunction

    // Number of operands entering level l after l ceiling halvings of n.
    function automatic int level_count(input int n, input int l);
        int c;
        c = n;
        for (int i = 0; i < l; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

endpackage

// File: rtl/tree_level.sv
// One registered pairwise-add level of the adder tree. valid/last ride along
// with the data so every level adds exactly one cycle of latency.
module tree_level #(
    parameter int N_IN = 2,
    parameter int W_IN = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic signed [W_IN-1:0] data_in  [N_IN],
    output logic                   out_valid,
    output logic                   out_last,
    output logic signed [W_IN:0]   data_out [(N_IN+1)/2]
);

    localparam int N_OUT = (N_IN + 1) / 2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_last  <= in_valid && in_last;
        end
    end

    // Data is qualified by out_valid downstream, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < N_IN / 2; j++) begin
            data_out[j] <= (W_IN+1)'(data_in[2*j]) + (W_IN+1)'(data_in[2*j+1]);
        end
        if (N_IN % 2 == 1) begin
            data_out[N_OUT-1] <= (W_IN+1)'(data_in[N_IN-1]);
        end
    end

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined signed N-lane adder tree followed by a group accumulator that
// emits one sum, beat count and sticky overflow flag per in_last-terminated group.
module adder_tree_acc
    import adder_tree_pkg::*;
#(
    parameter int N          = 32,
    parameter int DATA_WIDTH = 33,
    parameter int TREE_WIDTH = tree_width(N, DATA_WIDTH),
    parameter int ACC_WIDTH  = TREE_WIDTH + 8,
    parameter bit SATURATE   = 1'b0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic signed [DATA_WIDTH-1:0]  data_in [N],
    output logic                          out_valid,
    output logic signed [ACC_WIDTH-1:0]   out_sum,
    output logic        [CNT_WIDTH-1:0]   out_count,
    output logic                          out_overflow
);

    localparam int L = tree_depth(N);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic        [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Level l consumes level_count(N, l) operands of DATA_WIDTH+l bits.
    for (genvar l = 0; l < L; l++) begin : g_lvl
        localparam int NI = level_count(N, l);
        localparam int NO = level_count(N, l + 1);
        localparam int WI = DATA_WIDTH + l;

        logic              v_out;
        logic              l_out;
        logic signed [WI:0] d_out [NO];

        if (l == 0) begin : g_head
            tree_level #(
                .N_IN (NI),
                .W_IN (WI)
            ) u_level (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_last   (in_last),
                .data_in   (data_in),
                .out_valid (v_out),
                .out_last  (l_out),
                .data_out  (d_out)
            );
        end else begin : g_body
            tree_level #(
                .N_IN (NI),
                .W_IN (WI)
            ) u_level (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (g_lvl[l-1].v_out),
                .in_last   (g_lvl[l-1].l_out),
                .data_in   (g_lvl[l-1].d_out),
                .out_valid (v_out),
                .out_last  (l_out),
                .data_out  (d_out)
            );
        end
    end

    logic                          tree_valid;
    logic                          tree_last;
    logic signed [TREE_WIDTH-1:0]  tree_sum;

    assign tree_valid = g_lvl[L-1].v_out;
    assign tree_last  = g_lvl[L-1].l_out;
    assign tree_sum   = TREE_WIDTH'(g_lvl[L-1].d_out[0]);

    acc_state_t                    state;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic        [CNT_WIDTH-1:0]   cnt;
    logic                          ovf;

    logic signed [ACC_WIDTH-1:0]   beat_ext;
    logic signed [ACC_WIDTH-1:0]   add_raw;
    logic                          add_ovf;
    logic signed [ACC_WIDTH-1:0]   acc_nxt;
    logic        [CNT_WIDTH-1:0]   cnt_nxt;
    logic                          ovf_nxt;

    // The first beat of a group loads rather than adds, so it never overflows
    // and it clears the sticky flag left over from the previous group.
    always_comb begin
        beat_ext = ACC_WIDTH'(tree_sum);
        add_raw  = acc + beat_ext;
        add_ovf  = (acc[ACC_WIDTH-1] == beat_ext[ACC_WIDTH-1]) &&
                   (add_raw[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
        acc_nxt  = beat_ext;
        cnt_nxt  = CNT_WIDTH'(1);
        ovf_nxt  = 1'b0;
        if (state == ACC) begin
            acc_nxt = add_raw;
            if (SATURATE && add_ovf) begin
                acc_nxt = acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
            end
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_WIDTH'(1);
            ovf_nxt = ovf | add_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            out_valid <= tree_valid && tree_last;
            if (tree_valid) begin
                acc   <= acc_nxt;
                cnt   <= cnt_nxt;
                ovf   <= ovf_nxt;
                state <= tree_last ? IDLE : ACC;
                if (tree_last) begin
                    out_sum      <= acc_nxt;
                    out_count    <= cnt_nxt;
                    out_overflow <= ovf_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Bench for adder_tree_acc: several parameterisations share one clock and
// reset, each exercised by its own scenario task against a group-level model.
module tb_adder_tree_acc;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // N=32, DATA_WIDTH=8: TREE_WIDTH=14, ACC_WIDTH=22
    logic v32, l32, ov32, oo32;
    logic signed [7:0]  d32 [32];
    logic signed [21:0] os32;
    logic [15:0]        oc32;

    // N=5: TREE_WIDTH=11, ACC_WIDTH=19
    logic v5, l5, ov5, oo5;
    logic signed [7:0]  d5 [5];
    logic signed [18:0] os5;
    logic [15:0]        oc5;

    // N=1 with a 3-bit beat counter: TREE_WIDTH=9, ACC_WIDTH=17
    logic v1, l1, ov1, oo1;
    logic signed [7:0]  d1 [1];
    logic signed [16:0] os1;
    logic [2:0]         oc1;

    // N=2, ACC_WIDTH=10, saturating and wrapping copies on shared inputs
    logic vs, ls, ovs, oos, ovw, oow;
    logic signed [7:0]  ds [2];
    logic signed [9:0]  oss, osw;
    logic [15:0]        ocs, ocw;

    // N=7: TREE_WIDTH=11, ACC_WIDTH=19
    logic v7, l7, ov7, oo7;
    logic signed [7:0]  d7 [7];
    logic signed [18:0] os7;
    logic [15:0]        oc7;

    adder_tree_acc #(.N(32), .DATA_WIDTH(8)) u_n32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_last(l32), .data_in(d32),
        .out_valid(ov32), .out_sum(os32), .out_count(oc32), .out_overflow(oo32));

    adder_tree_acc #(.N(5), .DATA_WIDTH(8)) u_n5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_last(l5), .data_in(d5),
        .out_valid(ov5), .out_sum(os5), .out_count(oc5), .out_overflow(oo5));

    adder_tree_acc #(.N(1), .DATA_WIDTH(8), .CNT_WIDTH(3)) u_n1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_last(l1), .data_in(d1),
        .out_valid(ov1), .out_sum(os1), .out_count(oc1), .out_overflow(oo1));

    adder_tree_acc #(.N(2), .DATA_WIDTH(8), .ACC_WIDTH(10), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(vs), .in_last(ls), .data_in(ds),
        .out_valid(ovs), .out_sum(oss), .out_count(ocs), .out_overflow(oos));

    adder_tree_acc #(.N(2), .DATA_WIDTH(8), .ACC_WIDTH(10), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(vs), .in_last(ls), .data_in(ds),
        .out_valid(ovw), .out_sum(osw), .out_count(ocw), .out_overflow(oow));

    adder_tree_acc #(.N(7), .DATA_WIDTH(8)) u_n7 (
        .clk(clk), .rst_n(rst_n), .in_valid(v7), .in_last(l7), .data_in(d7),
        .out_valid(ov7), .out_sum(os7), .out_count(oc7), .out_overflow(oo7));

    // Group result from the arithmetic rules: exact sums with a range check
    // against the accumulator width, then clamp or modular wrap.
    function automatic void model_group(input longint beats[$], input int aw, input bit sat,
                                        input int cw, output longint sum, output longint cnt,
                                        output bit ovf);
        longint lo, hi, span, acc;
        lo   = -(longint'(1) <<< (aw - 1));
        hi   = (longint'(1) <<< (aw - 1)) - 1;
        span = hi - lo + 1;
        acc  = 0;
        ovf  = 1'b0;
        foreach (beats[i]) begin
            if (i == 0) begin
                acc = beats[i];
            end else begin
                acc = acc + beats[i];
                if (acc > hi || acc < lo) begin
                    ovf = 1'b1;
                    if (sat) acc = (acc > hi) ? hi : lo;
                    else     acc = (((acc - lo) % span) + span) % span + lo;
                end
            end
        end
        sum = acc;
        cnt = (longint'(beats.size()) > (longint'(1) <<< cw) - 1) ?
              (longint'(1) <<< cw) - 1 : longint'(beats.size());
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        v32 = 1'b0; l32 = 1'b0; v5 = 1'b0; l5 = 1'b0; v1 = 1'b0; l1 = 1'b0;
        vs = 1'b0; ls = 1'b0; v7 = 1'b0; l7 = 1'b0;
        foreach (d32[i]) d32[i] = '0;
        foreach (d5[i])  d5[i]  = '0;
        foreach (d1[i])  d1[i]  = '0;
        foreach (ds[i])  ds[i]  = '0;
        foreach (d7[i])  d7[i]  = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (ov32 !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", ov32); end
        tests_run++; if (os32 !== '0) begin tests_failed++; $display("FAIL reset_sum: got %0d expected 0", os32); end
        tests_run++; if (oc32 !== '0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", oc32); end
        tests_run++; if (oo32 !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", oo32); end
        tests_run++; if (oss !== '0 || ovs !== 1'b0) begin tests_failed++; $display("FAIL reset_sat: got sum %0d valid %b expected 0 0", oss, ovs); end
        #3 rst_n = 1'b1;
    endtask

    task automatic test_single_n32();
        int lat;
        @(posedge clk); #1;
        foreach (d32[i]) d32[i] = 8'sd1;
        v32 = 1'b1; l32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0; l32 = 1'b0;
        lat = 1;
        while (ov32 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        tests_run++; if (lat != 6) begin tests_failed++; $display("FAIL n32_latency: got %0d expected 6", lat); end
        tests_run++; if (os32 !== 22'sd32) begin tests_failed++; $display("FAIL n32_sum: got %0d expected 32", os32); end
        tests_run++; if (oc32 !== 16'd1) begin tests_failed++; $display("FAIL n32_count: got %0d expected 1", oc32); end
        tests_run++; if (oo32 !== 1'b0) begin tests_failed++; $display("FAIL n32_overflow: got %b expected 0", oo32); end
        @(posedge clk); #1;
        tests_run++; if (ov32 !== 1'b0) begin tests_failed++; $display("FAIL n32_pulse_width: got %b expected 0", ov32); end
    endtask

    task automatic test_gap_n5();
        int lanes [3][5] = '{'{1, -2, 3, -4, 5}, '{10, 10, 10, 10, 10}, '{-1, -1, -1, -1, -1}};
        int slot_beat [5] = '{0, 1, -1, -1, 2};
        longint beats[$];
        longint e_sum, e_cnt;
        bit     e_ovf;
        int     pulses = 0;
        for (int t = 0; t < 16; t++) begin
            @(posedge clk); #1;
            if (ov5 === 1'b1) begin
                pulses++;
                tests_run++; if (t != 8) begin tests_failed++; $display("FAIL n5_pulse_time: got %0d expected 8", t); end
                tests_run++; if (os5 !== 19'(e_sum)) begin tests_failed++; $display("FAIL n5_sum: got %0d expected %0d", os5, e_sum); end
                tests_run++; if (oc5 !== 16'(e_cnt)) begin tests_failed++; $display("FAIL n5_count: got %0d expected %0d", oc5, e_cnt); end
                tests_run++; if (oo5 !== e_ovf) begin tests_failed++; $display("FAIL n5_overflow: got %b expected %b", oo5, e_ovf); end
            end
            v5 = 1'b0; l5 = 1'b0;
            if (t < 5 && slot_beat[t] >= 0) begin
                longint s = 0;
                for (int i = 0; i < 5; i++) begin
                    d5[i] = 8'(lanes[slot_beat[t]][i]);
                    s += lanes[slot_beat[t]][i];
                end
                beats.push_back(s);
                v5 = 1'b1;
                l5 = (slot_beat[t] == 2);
                if (l5) model_group(beats, 19, 1'b0, 16, e_sum, e_cnt, e_ovf);
            end
        end
        tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL n5_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_back_to_back_n1();
        int vals [2] = '{7, -9};
        longint exp_sum_q[$];
        int     exp_t_q[$];
        int     pulses = 0;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            if (ov1 === 1'b1) begin
                pulses++;
                tests_run++;
                if (exp_sum_q.size() == 0) begin
                    tests_failed++; $display("FAIL n1_b2b_extra_pulse: got pulse at %0d expected none", t);
                end else begin
                    longint es = exp_sum_q.pop_front();
                    int     et = exp_t_q.pop_front();
                    if (t != et) begin tests_failed++; $display("FAIL n1_b2b_time: got %0d expected %0d", t, et); end
                    tests_run++; if (os1 !== 17'(es)) begin tests_failed++; $display("FAIL n1_b2b_sum: got %0d expected %0d", os1, es); end
                    tests_run++; if (oc1 !== 3'd1) begin tests_failed++; $display("FAIL n1_b2b_count: got %0d expected 1", oc1); end
                end
            end
            v1 = 1'b0; l1 = 1'b0;
            if (t < 2) begin
                d1[0] = 8'(vals[t]);
                v1 = 1'b1; l1 = 1'b1;
                exp_sum_q.push_back(longint'(vals[t]));
                exp_t_q.push_back(t + 2);
            end
        end
        tests_run++; if (pulses != 2) begin tests_failed++; $display("FAIL n1_b2b_pulses: got %0d expected 2", pulses); end
    endtask

    task automatic test_count_saturation_n1();
        longint beats[$];
        longint exp_sum_q[$], exp_cnt_q[$];
        bit     exp_ovf_q[$];
        longint e_sum, e_cnt;
        bit     e_ovf;
        int     pulses = 0;
        // Slots 0..8: a 9-beat group; slots 9..10: a 2-beat group right behind it.
        for (int t = 0; t < 16; t++) begin
            @(posedge clk); #1;
            if (ov1 === 1'b1) begin
                pulses++;
                tests_run++;
                if (exp_sum_q.size() == 0) begin
                    tests_failed++; $display("FAIL n1_cnt_extra_pulse: got pulse at %0d expected none", t);
                end else begin
                    longint es = exp_sum_q.pop_front();
                    longint ec = exp_cnt_q.pop_front();
                    bit     eo = exp_ovf_q.pop_front();
                    if (oc1 !== 3'(ec)) begin tests_failed++; $display("FAIL n1_cnt_count: got %0d expected %0d", oc1, ec); end
                    tests_run++; if (os1 !== 17'(es)) begin tests_failed++; $display("FAIL n1_cnt_sum: got %0d expected %0d", os1, es); end
                    tests_run++; if (oo1 !== eo) begin tests_failed++; $display("FAIL n1_cnt_overflow: got %b expected %b", oo1, eo); end
                end
            end
            v1 = 1'b0; l1 = 1'b0;
            if (t < 11) begin
                d1[0] = 8'($urandom_range(255));
                beats.push_back(longint'(d1[0]));
                v1 = 1'b1;
                l1 = (t == 8 || t == 10);
                if (l1) begin
                    model_group(beats, 17, 1'b0, 3, e_sum, e_cnt, e_ovf);
                    exp_sum_q.push_back(e_sum); exp_cnt_q.push_back(e_cnt); exp_ovf_q.push_back(e_ovf);
                    beats.delete();
                end
            end
        end
        tests_run++; if (pulses != 2) begin tests_failed++; $display("FAIL n1_cnt_pulses: got %0d expected 2", pulses); end
    endtask

    task automatic test_saturate_wrap();
        int vals [7] = '{127, 127, 127, 1, -128, -128, -128};
        bit lasts [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        longint beats[$];
        longint sat_sum_q[$], wrap_sum_q[$], cnt_q[$];
        bit     sat_ovf_q[$], wrap_ovf_q[$];
        longint e_sum, e_cnt;
        bit     e_ovf;
        int     n_last = 0, pulses_s = 0, pulses_w = 0;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1;
            if (ovs === 1'b1) begin
                pulses_s++;
                tests_run++;
                if (sat_sum_q.size() == 0) begin
                    tests_failed++; $display("FAIL sat_extra_pulse: got pulse at %0d expected none", t);
                end else begin
                    longint es = sat_sum_q.pop_front();
                    longint ec = cnt_q.pop_front();
                    bit     eo = sat_ovf_q.pop_front();
                    if (oss !== 10'(es)) begin tests_failed++; $display("FAIL sat_sum: got %0d expected %0d", oss, es); end
                    tests_run++; if (oos !== eo) begin tests_failed++; $display("FAIL sat_overflow: got %b expected %b", oos, eo); end
                    tests_run++; if (ocs !== 16'(ec)) begin tests_failed++; $display("FAIL sat_count: got %0d expected %0d", ocs, ec); end
                end
            end
            if (ovw === 1'b1) begin
                pulses_w++;
                tests_run++;
                if (wrap_sum_q.size() == 0) begin
                    tests_failed++; $display("FAIL wrap_extra_pulse: got pulse at %0d expected none", t);
                end else begin
                    longint es = wrap_sum_q.pop_front();
                    bit     eo = wrap_ovf_q.pop_front();
                    if (osw !== 10'(es)) begin tests_failed++; $display("FAIL wrap_sum: got %0d expected %0d", osw, es); end
                    tests_run++; if (oow !== eo) begin tests_failed++; $display("FAIL wrap_overflow: got %b expected %b", oow, eo); end
                    tests_run++; if (ocw !== ocs) begin tests_failed++; $display("FAIL wrap_count: got %0d expected %0d", ocw, ocs); end
                end
            end
            vs = 1'b0; ls = 1'b0;
            if (t < 7) begin
                ds[0] = 8'(vals[t]); ds[1] = 8'(vals[t]);
                beats.push_back(2 * longint'(vals[t]));
                vs = 1'b1; ls = lasts[t];
                if (ls) begin
                    n_last++;
                    model_group(beats, 10, 1'b1, 16, e_sum, e_cnt, e_ovf);
                    sat_sum_q.push_back(e_sum); sat_ovf_q.push_back(e_ovf); cnt_q.push_back(e_cnt);
                    model_group(beats, 10, 1'b0, 16, e_sum, e_cnt, e_ovf);
                    wrap_sum_q.push_back(e_sum); wrap_ovf_q.push_back(e_ovf);
                    beats.delete();
                end
            end
        end
        tests_run++; if (pulses_s != n_last) begin tests_failed++; $display("FAIL sat_pulses: got %0d expected %0d", pulses_s, n_last); end
        tests_run++; if (pulses_w != n_last) begin tests_failed++; $display("FAIL wrap_pulses: got %0d expected %0d", pulses_w, n_last); end
    endtask

    task automatic test_reset_mid_group();
        int pulses = 0;
        int lat;
        @(posedge clk); #1;
        foreach (d32[i]) d32[i] = 8'($urandom_range(255));
        v32 = 1'b1; l32 = 1'b0;
        @(posedge clk); #1;
        foreach (d32[i]) d32[i] = 8'($urandom_range(255));
        #2 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        v32 = 1'b0;
        tests_run++; if (os32 !== '0 || oc32 !== '0) begin tests_failed++; $display("FAIL midreset_clear: got sum %0d count %0d expected 0 0", os32, oc32); end
        for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1;
            if (ov32 === 1'b1) pulses++;
        end
        tests_run++; if (pulses != 0) begin tests_failed++; $display("FAIL midreset_pulses: got %0d expected 0", pulses); end
        foreach (d32[i]) d32[i] = 8'sd2;
        v32 = 1'b1; l32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0; l32 = 1'b0;
        lat = 1;
        while (ov32 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        tests_run++; if (lat != 6) begin tests_failed++; $display("FAIL midreset_latency: got %0d expected 6", lat); end
        tests_run++; if (os32 !== 22'sd64) begin tests_failed++; $display("FAIL midreset_sum: got %0d expected 64", os32); end
        tests_run++; if (oc32 !== 16'd1) begin tests_failed++; $display("FAIL midreset_count: got %0d expected 1", oc32); end
    endtask

    task automatic test_random_stream_n7();
        localparam int CYC = 400;
        longint beats[$];
        longint exp_sum_q[$], exp_cnt_q[$];
        bit     exp_ovf_q[$];
        longint e_sum, e_cnt;
        bit     e_ovf;
        int     n_last = 0, pulses = 0;
        for (int t = 0; t < CYC + 10; t++) begin
            @(posedge clk); #1;
            if (ov7 === 1'b1) begin
                pulses++;
                tests_run++;
                if (exp_sum_q.size() == 0) begin
                    tests_failed++; $display("FAIL n7_extra_pulse: got pulse at %0d expected none", t);
                end else begin
                    longint es = exp_sum_q.pop_front();
                    longint ec = exp_cnt_q.pop_front();
                    bit     eo = exp_ovf_q.pop_front();
                    if (os7 !== 19'(es)) begin tests_failed++; $display("FAIL n7_sum: got %0d expected %0d", os7, es); end
                    tests_run++; if (oc7 !== 16'(ec)) begin tests_failed++; $display("FAIL n7_count: got %0d expected %0d", oc7, ec); end
                    tests_run++; if (oo7 !== eo) begin tests_failed++; $display("FAIL n7_overflow: got %b expected %b", oo7, eo); end
                end
            end
            v7 = 1'b0;
            l7 = ($urandom_range(3) == 0);
            if (t < CYC && ($urandom_range(3) != 0 || t == CYC - 1)) begin
                longint s = 0;
                for (int i = 0; i < 7; i++) begin
                    d7[i] = 8'($urandom_range(255));
                    s += longint'(d7[i]);
                end
                beats.push_back(s);
                v7 = 1'b1;
                if (t == CYC - 1) l7 = 1'b1;
                if (l7) begin
                    n_last++;
                    model_group(beats, 19, 1'b0, 16, e_sum, e_cnt, e_ovf);
                    exp_sum_q.push_back(e_sum); exp_cnt_q.push_back(e_cnt); exp_ovf_q.push_back(e_ovf);
                    beats.delete();
                end
            end
        end
        v7 = 1'b0; l7 = 1'b0;
        tests_run++; if (pulses != n_last) begin tests_failed++; $display("FAIL n7_pulses: got %0d expected %0d", pulses, n_last); end
        tests_run++; if (exp_sum_q.size() != 0) begin tests_failed++; $display("FAIL n7_pending: got %0d expected 0", exp_sum_q.size()); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single_n32();
        test_gap_n5();
        test_back_to_back_n1();
        test_count_saturation_n1();
        test_saturate_wrap();
        test_reset_mid_group();
        test_random_stream_n7();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
